// File: rtl/uart_tx_arbiter_if.sv
// Requester/serializer bundle for uart_tx_arbiter.
// master: the arbiter side. slave: requesters plus serializer.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]      i_req_valid;
  logic [N_REQ-1:0][7:0] i_req_data;   // requester k occupies bits [8k+7:8k]
  logic [N_REQ-1:0]      i_req_last;
  logic [N_REQ-1:0]      o_req_ready;
  logic                  o_tx_start;
  logic [7:0]            o_tx_data;
  logic                  i_tx_done;
  logic                  i_tx_busy;
  logic [N_REQ-1:0]      o_grant;
  logic                  o_active;
  logic                  o_frame_done;
  logic                  o_timeout;
  logic                  o_err;

  modport master (
    input  i_req_valid, i_req_data, i_req_last, i_tx_done, i_tx_busy,
    output o_req_ready, o_tx_start, o_tx_data, o_grant, o_active,
           o_frame_done, o_timeout, o_err
  );

  modport slave (
    output i_req_valid, i_req_data, i_req_last, i_tx_done, i_tx_busy,
    input  o_req_ready, o_tx_start, o_tx_data, o_grant, o_active,
           o_frame_done, o_timeout, o_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic sharing of one uart_tx serializer between
// N_REQ byte-stream requesters, with a stall watchdog. All outputs are
// registered or decoded from registered state.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 4860,
  parameter int TIMEOUT_W   = 13
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLD} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, gidx, sel, cand;
  logic                 sel_vld;
  logic [N_REQ-1:0]     grant_q, req_ready;
  logic [7:0]           data_q;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 last_q, active_q, fd_q, to_q, err_q, tx_start;
  logic                 wd_hit, own_vld;
  logic                 unused_busy;

  // Serializer busy is status only; sequencing relies on the done pulse.
  assign unused_busy = bus.i_tx_busy;

  assign wd_hit  = (wdog == TIMEOUT_W'(TIMEOUT_CYC - 1));
  assign own_vld = bus.i_req_valid[gidx];

  // Round-robin pick: nearest valid requester after rr_ptr, with wrap.
  // Walk from the farthest offset down so the nearest one is written last.
  always_comb begin
    sel     = rr_ptr;
    sel_vld = 1'b0;
    cand    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (bus.i_req_valid[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; done or owner-valid takes priority over the watchdog.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (sel_vld) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.i_tx_done) begin
          if (last_q)       state_nxt = IDLE;
          else if (own_vld) state_nxt = START;
          else              state_nxt = HOLD;
        end else if (wd_hit) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (own_vld)     state_nxt = START;
        else if (wd_hit) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Moore decode: START is the byte handshake cycle with the owner.
  always_comb begin
    tx_start  = 1'b0;
    req_ready = '0;
    if (state == START) begin
      tx_start  = 1'b1;
      req_ready = grant_q;
    end
  end

  // Grant, byte, last flag, watchdog and event pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr   <= IDX_W'(N_REQ - 1);
      gidx     <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
      wdog     <= '0;
      fd_q     <= 1'b0;
      to_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      to_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_vld) begin
            gidx          <= sel;
            grant_q       <= '0;
            grant_q[sel]  <= 1'b1;
            active_q      <= 1'b1;
            data_q        <= bus.i_req_data[sel];
          end
        end
        START: begin
          last_q <= bus.i_req_last[gidx];
          wdog   <= '0;
        end
        WAIT_DONE: begin
          if (bus.i_tx_done) begin
            if (last_q) begin
              fd_q     <= 1'b1;
              rr_ptr   <= gidx;
              grant_q  <= '0;
              active_q <= 1'b0;
            end else if (own_vld) begin
              data_q <= bus.i_req_data[gidx];
            end else begin
              wdog <= '0;               // fresh budget for the owner in HOLD
            end
          end else if (wd_hit) begin
            to_q     <= 1'b1;
            err_q    <= 1'b1;
            rr_ptr   <= gidx;
            grant_q  <= '0;
            active_q <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        HOLD: begin
          if (own_vld) begin
            data_q <= bus.i_req_data[gidx];
          end else if (wd_hit) begin
            to_q     <= 1'b1;
            err_q    <= 1'b1;
            rr_ptr   <= gidx;
            grant_q  <= '0;
            active_q <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_tx_start   = tx_start;
  assign bus.o_tx_data    = data_q;
  assign bus.o_grant      = grant_q;
  assign bus.o_active     = active_q;
  assign bus.o_frame_done = fd_q;
  assign bus.o_timeout    = to_q;
  assign bus.o_err        = err_q;

endmodule
